// File: rtl/loop_sched_pkg.sv
// Shared types and constants for the loop scheduler.
// Provides op codes, scheduler states and default sizes.
package definitions;

  localparam int unsigned PC_WIDTH_DEF    = 16;
  localparam int unsigned STACK_DEPTH_DEF = 8;
  localparam int unsigned INSTR_W         = 9;
  localparam int unsigned DATA_W          = 8;

  typedef enum logic [INSTR_W-1:0] {
    NOP   = 9'h000,
    INC   = 9'h001,
    DEC   = 9'h002,
    RIGHT = 9'h003,
    LEFT  = 9'h004,
    OUTP  = 9'h005,
    INP   = 9'h006,
    CBF   = 9'h007,
    CBB   = 9'h008
  } op_code;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    SKIP = 2'd1,
    ERR  = 2'd2
  } sched_state_t;

endpackage

// File: rtl/loop_sched_if.sv
// Fetch/datapath-facing bundle of the loop scheduler.
// master: scheduler side (en/instruction/mem_read in; pc/stall/depth/err out).
interface loop_sched_if
  import definitions::*;
#(
  parameter int unsigned PCWidth    = PC_WIDTH_DEF,
  parameter int unsigned StackDepth = STACK_DEPTH_DEF
);

  logic                          en;
  logic [INSTR_W-1:0]            instruction;
  logic [DATA_W-1:0]             mem_read;
  logic [PCWidth-1:0]            pc;
  logic                          stall;
  logic [$clog2(StackDepth):0]   depth;
  logic                          err;

  modport master (
    input  en,
    input  instruction,
    input  mem_read,
    output pc,
    output stall,
    output depth,
    output err
  );

  modport slave (
    output en,
    output instruction,
    output mem_read,
    input  pc,
    input  stall,
    input  depth,
    input  err
  );

endinterface

// File: rtl/loop_sched_stack.sv
// Register LIFO of loop-body start addresses.
// Ports: push/pop/push_data in; top/depth/full/empty out.
module loop_stack
  import definitions::*;
#(
  parameter int unsigned Width = PC_WIDTH_DEF,
  parameter int unsigned Depth = STACK_DEPTH_DEF
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic [Width-1:0]           push_data,
  output logic [Width-1:0]           top,
  output logic [$clog2(Depth):0]     depth,
  output logic                       full,
  output logic                       empty
);

  localparam int unsigned AW = $clog2(Depth);
  localparam int unsigned DW = AW + 1;

  logic [Width-1:0] mem_q [Depth];
  logic [Width-1:0] mem_d [Depth];
  logic [DW-1:0]    depth_q;
  logic [DW-1:0]    depth_d;
  logic [AW-1:0]    wr_idx;
  logic [AW-1:0]    rd_idx;

  assign full   = (depth_q == DW'(Depth));
  assign empty  = (depth_q == '0);
  assign wr_idx = depth_q[AW-1:0];
  // Wraps to the last slot when full, which is the newest entry.
  assign rd_idx = wr_idx - 1'b1;
  assign top    = mem_q[rd_idx];
  assign depth  = depth_q;

  always_comb begin
    mem_d   = mem_q;
    depth_d = depth_q;
    if (push && !full) begin
      mem_d[wr_idx] = push_data;
      depth_d       = depth_q + 1'b1;
    end else if (pop && !empty) begin
      depth_d = depth_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      depth_q <= '0;
      mem_q   <= '{default: '0};
    end else begin
      depth_q <= depth_d;
      mem_q   <= mem_d;
    end
  end

endmodule

// File: rtl/loop_sched.sv
// PC sequencer for CBF/CBB loop brackets with a loop stack.
// Ports: clk, reset (async, active low), bus (loop_sched_if.master).
module loop_sched
  import definitions::*;
#(
  parameter int unsigned PCWidth    = PC_WIDTH_DEF,
  parameter int unsigned StackDepth = STACK_DEPTH_DEF
) (
  input  logic              clk,
  input  logic              reset,
  loop_sched_if.master      bus
);

  localparam int unsigned DW = $clog2(StackDepth) + 1;

  localparam logic [1:0] S_RUN  = RUN;
  localparam logic [1:0] S_SKIP = SKIP;
  localparam logic [1:0] S_ERR  = ERR;

  localparam logic [PCWidth-1:0] SkipMax = '1;

  logic [PCWidth-1:0] pc_q;
  logic [PCWidth-1:0] pc_d;
  logic [1:0]         state_q;
  logic [1:0]         state_d;
  logic [PCWidth-1:0] skip_q;
  logic [PCWidth-1:0] skip_d;

  logic               push;
  logic               pop;
  logic [PCWidth-1:0] top;
  logic [DW-1:0]      depth;
  logic               full;
  logic               empty;

  logic               is_cbf;
  logic               is_cbb;
  logic               mem_nz;
  logic [PCWidth-1:0] pc_inc;

  assign is_cbf = (bus.instruction == CBF);
  assign is_cbb = (bus.instruction == CBB);
  assign mem_nz = |bus.mem_read;
  assign pc_inc = pc_q + 1'b1;

  loop_stack #(
    .Width (PCWidth),
    .Depth (StackDepth)
  ) u_stack (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .pop       (pop),
    .push_data (pc_inc),
    .top       (top),
    .depth     (depth),
    .full      (full),
    .empty     (empty)
  );

  always_comb begin
    pc_d    = pc_q;
    state_d = state_q;
    skip_d  = skip_q;
    push    = 1'b0;
    pop     = 1'b0;
    if (bus.en) begin
      case (state_q)
        S_RUN: begin
          unique case (1'b1)
            is_cbf: begin
              if (!mem_nz) begin
                state_d = S_SKIP;
                skip_d  = PCWidth'(1);
                pc_d    = pc_inc;
              end else if (full) begin
                state_d = S_ERR;
              end else begin
                push = 1'b1;
                pc_d = pc_inc;
              end
            end
            is_cbb: begin
              if (empty) begin
                state_d = S_ERR;
              end else if (mem_nz) begin
                // Jump straight into the body; CBF is not re-run.
                pc_d = top;
              end else begin
                pop  = 1'b1;
                pc_d = pc_inc;
              end
            end
            default: pc_d = pc_inc;
          endcase
        end
        S_SKIP: begin
          pc_d = pc_inc;
          unique case (1'b1)
            is_cbf: begin
              if (skip_q != SkipMax) begin
                skip_d = skip_q + 1'b1;
              end
            end
            is_cbb: begin
              if (skip_q > PCWidth'(1)) begin
                skip_d = skip_q - 1'b1;
              end else begin
                skip_d  = '0;
                state_d = S_RUN;
              end
            end
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q    <= '0;
      state_q <= S_RUN;
      skip_q  <= '0;
    end else begin
      pc_q    <= pc_d;
      state_q <= state_d;
      skip_q  <= skip_d;
    end
  end

  assign bus.pc    = pc_q;
  assign bus.stall = (state_q != S_RUN);
  assign bus.err   = (state_q == S_ERR);
  assign bus.depth = depth;

endmodule

// File: doc/loop_sched.md
Name: loop_sched

Overview:
- Sequences the program counter around BeeF loop brackets: CBF (loop open) and CBB (loop close).
- Keeps a hardware stack of loop-body start addresses, so a taken CBB jumps back in one cycle.
- On a CBF with a zero cell, it skips forward past the matching CBB and holds `stall` high to suppress datapath side effects while skipping.
- Sits between instruction fetch and the datapath, and replaces the simple pc_ctrl branch logic.

Parameters:
- `PCWidth`, default 16: width of `pc`, of the stack entries and of the skip nesting counter.
- `StackDepth`, default 8: number of loop stack entries; must be a power of 2 and at least 2.

Ports:
- `clk`  in  1: single clock; all state updates on the rising edge.
- `reset`  in  1: asynchronous, active-low reset. Asserting it low clears state immediately.
- `en`  in  1: advance enable. When low, all state holds.
- `instruction`  in  9: op_code of the word currently at `pc`. The fetch path is combinational from `pc`.
- `mem_read`  in  8: current data cell value, valid in the same cycle as `instruction`.
- `pc`  out  PCWidth: address of the instruction being executed.
- `stall`  out  1: high means the datapath must not write memory, pointer or IO this cycle.
- `depth`  out  $clog2(StackDepth)+1: number of live stack entries.
- `err`  out  1: sticky error flag, set on stack overflow or underflow.

Behaviour:
- Reset values (reset low): `pc`=0, state=RUN, `depth`=0, skip count=0, `stall`=0, `err`=0. Stack contents are don't-care.
- State and `depth` update one cycle after decode; the next `pc` is presented on the next rising edge.
- `stall` is combinational from state: 1 in SKIP and ERR, 0 in RUN.
- `en`=0: `pc`, state, stack, `depth` and skip count all hold. `stall` still reflects the current state.
- `pc` arithmetic is modulo 2^PCWidth: `pc`=2^PCWidth-1 plus 1 wraps to 0, with no flag.
- State RUN, per instruction (with `en`=1):
  - Non-branch op: `pc`<=`pc`+1.
  - CBF with `mem_read`!=0 and `depth`<StackDepth: push `pc`+1, `depth`+1, `pc`<=`pc`+1.
  - CBF with `mem_read`!=0 and `depth`==StackDepth: go to ERR, `err`<=1, `pc` holds.
  - CBF with `mem_read`==0: no push. Go to SKIP, skip count<=1, `pc`<=`pc`+1.
  - CBB with `mem_read`!=0 and `depth`>0: `pc`<=top of stack. Stack is unchanged; the loop re-enters its body directly, without re-executing CBF.
  - CBB with `mem_read`==0 and `depth`>0: pop, `depth`-1, `pc`<=`pc`+1.
  - CBB with `depth`==0, either `mem_read` value: go to ERR, `err`<=1, `pc` holds.
- State SKIP: `pc`<=`pc`+1 every cycle. `mem_read` is ignored and the stack is untouched.
  - CBF: skip count+1.
  - CBB with skip count>1: skip count-1.
  - CBB with skip count==1: skip count<=0, go to RUN. `stall` drops on the following cycle.
  - Skip count saturates at 2^PCWidth-1. No error is raised in SKIP.
- State ERR: `pc`, stack and `depth` are frozen, `stall`=1, `err`=1. Only `reset` exits ERR.
- Reset asserted mid-operation, including mid-SKIP or with a full stack: immediate return to reset values. No partial state survives.
- A full stack with CBB taken is legal: there is no push, so it cannot overflow.

Decomposition:
- `definitions` package:
  - `op_code` enum, including NOP, CBF, CBB.
  - `sched_state_t` enum {RUN, SKIP, ERR}.
  - Default-width constants for `PCWidth` and `StackDepth`.
- One sub-module, `loop_stack`: LIFO with push, pop, top, `depth`, full and empty; register-based, with the same `clk` and `reset`.
- `loop_sched` holds the FSM, the skip counter and the `pc` register.

Test Plan:
1. Program [0]NOP [1]NOP: after reset release, `pc` reads 0,1,2 on consecutive edges; `stall` stays 0.
2. [0]CBF [1]NOP [2]CBB with `mem_read`=8'hBF for two passes, then 8'h00 at CBB:
   - `pc` sequence is 0,1,2,1,2,1,2,3.
   - `depth` is 1 after the CBF and 0 after the final CBB.
3. [0]CBF [1]CBF [2]NOP [3]CBB [4]CBB [5]NOP with `mem_read`=0 at `pc`=0:
   - `stall`=1 for `pc`=1..4.
   - `depth` stays 0.
   - RUN resumes at `pc`=5 with `stall`=0.
4. StackDepth=8, nine nested CBF, all with `mem_read`=8'hEF: the ninth CBF sets `err`=1, `stall`=1, and freezes `pc` at 8.
5. CBB at `pc`=0 with `depth`=0: `err`=1 on the next edge; `pc` stays 0.
6. Reset cases:
   - Drop `reset` low mid-SKIP: `pc`=0, `stall`=0, `depth`=0 immediately, with no clock edge needed.
   - `en`=0 for 3 cycles in RUN: `pc` holds.
   - A run of non-branch ops from `pc`=16'hFFFF wraps `pc` to 16'h0000.
